breathing_pwm: RTL
==================

Name: breathing_pwm

Overview:
- Consumer of the periodic one-cycle step pulse from the pulse generator. Produces a PWM output whose duty cycle ramps up, dwells, ramps down and dwells, repeating forever (LED "breathing").
- Each step pulse advances the duty ramp by one stage.
- A free-running PWM counter, with a shadow duty register latched at period wrap, gives glitch-free output.

Parameters:
N, 8, width of PWM counter, duty and max_duty; PWM period is 2^N clocks
HOLD, 4, number of step pulses spent dwelling at top and at bottom; legal range 1..255

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  asynchronous, active-low reset (asserted when 0); clears all state immediately
ena  input  1  global enable; when 0 all state frozen
step  input  1  one-cycle ramp-advance pulse from pulse generator
max_duty  input  N  ramp ceiling, sampled on every step
out  output  1  PWM output
duty  output  N  current ramp duty (pre-shadow)
phase  output  2  current FSM state (phase_t encoding)
wrap  output  1  high for the last cycle of each PWM period

Behaviour:
- Reset (rst=0, async): pwm_count=0, duty=0, duty_shadow=0, hold_cnt=0, phase=S_BOTTOM. Outputs out=0, wrap=0 during and after reset.
- PWM counter:
  - When ena=1, pwm_count increments by 1 every clock, wrapping 2^N-1 -> 0 (mod 2^N).
  - wrap = ena & (pwm_count == 2^N-1).
  - On a wrap cycle, duty_shadow <= duty, capturing the value before any same-cycle step update.
- out = ena & (pwm_count < duty_shadow), combinational from registers.
  - duty_shadow=0 gives constantly low.
  - duty_shadow=2^N-1 gives low for exactly 1 of 2^N cycles.
- FSM (phase_t): S_BOTTOM=2'b00, S_UP=2'b01, S_TOP=2'b10, S_DOWN=2'b11. It advances only on cycles with ena & step.
  - S_BOTTOM: if hold_cnt==HOLD-1 -> hold_cnt=0, go S_UP; else hold_cnt++. Dwell is exactly HOLD steps.
  - S_UP: next = (duty < max_duty) ? duty+1 : max_duty (clamps if max_duty lowered mid-ramp). duty <= next. If next >= max_duty, go S_TOP with hold_cnt=0.
  - S_UP with max_duty=0: duty <= 0, go S_TOP.
  - S_TOP: same hold rule as S_BOTTOM; exit to S_DOWN.
  - S_DOWN: if duty==0, go S_BOTTOM with no decrement. Else duty <= duty-1; if duty-1==0, go S_BOTTOM with hold_cnt=0.
- Arithmetic: duty is never below 0 or above max(max_duty at last step, 0). No overflow is possible at duty=2^N-1 because S_UP exits on reaching max_duty.
- ena=0: pwm_count, duty, shadow, hold_cnt and phase all hold. Steps are ignored. out=0, wrap=0. Operation resumes from the identical state when ena returns to 1.
- Step and wrap in the same cycle: the shadow takes the old duty; the new duty appears in the following period.
- step held high for multiple cycles: each high cycle is a separate step.
- Reset mid-ramp: returns to S_BOTTOM with duty 0 asynchronously; out drops within the same cycle.

Decomposition:
- Package breathing_pwm_pkg: enum phase_t (2-bit encoding above) and localparam PHASE_W=2.
- Sub-module pwm_core (params N; ports clk, rst, ena, duty, out, wrap): holds the counter, the shadow register and the compare.
- The FSM and hold counter stay in breathing_pwm.

Test Plan:
- Reset: run to S_UP with duty=3, drive rst=0 mid-cycle -> immediately phase=00, duty=0, out=0, wrap=0; after release, out stays 0 for a full period.
- Ramp sequence (N=4, HOLD=2, max_duty=3, step every cycle, ena=1):
  - phase goes BOTTOM for 2 steps, then UP with duty 1,2,3, then TOP for 2 steps.
  - Then DOWN with duty 2,1,0, then BOTTOM; the cycle repeats.
- PWM duty (N=4, duty forced to 5 via steps, then step=0): out high exactly 5 of every 16 clocks, at pwm_count 0..4; wrap high once per 16 clocks, at count 15.
- Shadow timing:
  - Step raising duty 5->6 at pwm_count=7 -> current period still shows 5 high cycles, the next period shows 6.
  - Step coincident with wrap -> the following period shows the old duty.
- Clamp and zero (N=4):
  - In S_UP with duty=5, set max_duty=2, then step -> duty=2, phase=TOP.
  - max_duty=0 -> S_UP exits to TOP on its first step, with duty 0.
- Enable gating: ena=0 for 20 clocks with step pulses applied -> out=0, wrap=0, duty/phase/pwm_count unchanged; after ena=1 the sequence continues from the frozen point.

Source files
------------

// File: rtl/breathing_pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : breathing_pwm_pkg
//  Description : Shared types for the breathing PWM block (ramp phase
//                encoding and its width).
//  Revision    : 1.0 - initial release
// ============================================================================
package breathing_pwm_pkg;

    localparam int PHASE_W = 2;

    typedef enum logic [PHASE_W-1:0] {
        S_BOTTOM = 2'b00,
        S_UP     = 2'b01,
        S_TOP    = 2'b10,
        S_DOWN   = 2'b11
    } phase_t;

endpackage : breathing_pwm_pkg
`default_nettype wire

// File: rtl/breathing_pwm_pwm_core.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_core
//  Description : Free-running N-bit PWM counter with a shadow duty register
//                that is reloaded only at period wrap, so a duty change never
//                truncates or stretches the period in progress.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_core #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [N-1:0] duty,
    output logic         out,
    output logic         wrap
);

    logic [N-1:0] r_count;
    logic [N-1:0] r_shadow;
    logic         w_last;

    assign w_last = (r_count == {N{1'b1}});
    assign wrap   = ena & w_last;
    assign out    = ena & (r_count < r_shadow);

    // Counter advances while enabled; the shadow takes the pre-update duty at wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count  <= '0;
            r_shadow <= '0;
        end else if (ena) begin
            r_count <= r_count + 1'b1;
            if (w_last) begin
                r_shadow <= duty;
            end
        end
    end

endmodule : pwm_core
`default_nettype wire

// File: rtl/breathing_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : breathing_pwm
//  Description : LED "breathing" generator. Each step pulse advances a duty
//                ramp (dwell at bottom, ramp up, dwell at top, ramp down);
//                the ramp duty drives a glitch-free PWM core.
//  Revision    : 1.0 - initial release
// ============================================================================
module breathing_pwm
    import breathing_pwm_pkg::*;
#(
    parameter int N    = 8,
    parameter int HOLD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               step,
    input  logic [N-1:0]       max_duty,
    output logic               out,
    output logic [N-1:0]       duty,
    output logic [PHASE_W-1:0] phase,
    output logic               wrap
);

    localparam logic [7:0] c_HOLD_LAST = 8'(HOLD - 1);

    phase_t       r_phase;
    logic [N-1:0] r_duty;
    logic [7:0]   r_hold_cnt;
    logic         w_adv;
    logic [N-1:0] w_up_next;

    assign w_adv     = ena & step;
    // Clamp to the ceiling if it was lowered below the current duty mid-ramp.
    assign w_up_next = (r_duty < max_duty) ? (r_duty + 1'b1) : max_duty;

    assign duty  = r_duty;
    assign phase = r_phase;

    // Ramp state machine: moves one stage per enabled step pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase    <= S_BOTTOM;
            r_duty     <= '0;
            r_hold_cnt <= '0;
        end else if (w_adv) begin
            case (r_phase)
                S_BOTTOM: begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_hold_cnt <= '0;
                        r_phase    <= S_UP;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                S_UP: begin
                    r_duty <= w_up_next;
                    if (w_up_next >= max_duty) begin
                        r_hold_cnt <= '0;
                        r_phase    <= S_TOP;
                    end
                end
                S_TOP: begin
                    if (r_hold_cnt == c_HOLD_LAST) begin
                        r_hold_cnt <= '0;
                        r_phase    <= S_DOWN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                S_DOWN: begin
                    if (r_duty == '0) begin
                        r_hold_cnt <= '0;
                        r_phase    <= S_BOTTOM;
                    end else begin
                        r_duty <= r_duty - 1'b1;
                        if (r_duty == {{(N-1){1'b0}}, 1'b1}) begin
                            r_hold_cnt <= '0;
                            r_phase    <= S_BOTTOM;
                        end
                    end
                end
                default: begin
                    r_phase <= S_BOTTOM;
                end
            endcase
        end
    end

    pwm_core #(
        .N (N)
    ) u_pwm_core (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .duty (r_duty),
        .out  (out),
        .wrap (wrap)
    );

endmodule : breathing_pwm
`default_nettype wire
